gcd_result_display: RTL
=======================

Name: gcd_result_display

Overview:
- Downstream stage of the GCD datapath. Accepts each finished 8-bit GCD result over a valid/ready handshake.
- Converts the result to BCD with an iterative shift-and-add-3 (double-dabble) engine.
- Drives three registered seven-segment digit outputs (HEX0..HEX2 on the board), which hold the last result until the next conversion completes.

Parameters:
- WIDTH, 8, binary input width.
- DIGITS, 3, number of BCD digits. Must be >= ceil(WIDTH*log10(2)); elaboration error otherwise.
- SEG_ACTIVE_LOW, 1, 1 = segment lit when bit is 0 (board default); 0 = active-high.

Ports:
- clk  in  1  system clock (125 MHz)
- rst  in  1  synchronous reset, active-high
- res_valid  in  1  producer has a result on res_data
- res_data  in  WIDTH  unsigned GCD result
- res_ready  out  1  block can accept a result
- hex  out  7*DIGITS  segment vectors; digit i in bits [7i+6:7i]; bit0=a ... bit6=g
- busy  out  1  conversion in progress
- done  out  1  one-cycle pulse when hex updates

Behaviour:
- Reset (rst=1 at a clk edge, in any state, including mid-conversion):
  - state IDLE, res_ready=1, busy=0, done=0.
  - All digits blank: all segments off, i.e. 7'h7F if active-low, 7'h00 if active-high.
  - Any in-flight conversion is discarded.
- Handshake:
  - Transfer occurs on an edge where res_valid && res_ready.
  - res_ready = (state==IDLE), registered.
  - res_data is sampled only at transfer. Producer must hold res_valid/res_data until transfer; the block never drops a held request.
- FSM:
  - IDLE: on transfer, load shift reg = res_data, clear BCD reg to 0, load iteration count = WIDTH, go to SHIFT.
  - SHIFT: once per cycle, for each BCD digit >= 5 add 3 (all digits in parallel). Then shift {bcd, bin} left by 1 and decrement count. After the WIDTH-th shift, go to LATCH.
  - LATCH: encode BCD digits to segments and register them into hex. Set done=1 for this one cycle and go to IDLE.
- Latency:
  - If transfer is at edge k, hex changes and done=1 become visible after edge k+WIDTH+1 (9 edges for WIDTH=8).
  - res_ready goes high after edge k+WIDTH+2.
- busy=1 in SHIFT and LATCH.
- hex holds its previous value throughout a conversion; no intermediate values are ever visible.
- BCD arithmetic: each digit is 4 bits. The add-3 is applied only to digits >= 5, before the shift. Maximum input 2^WIDTH-1 must fit in DIGITS digits.
- Segment encoding (active-high, before polarity inversion):
  - 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F, blank:00.
  - Codes 10-15 cannot occur; map them to blank.
- Back-to-back: a new result may be accepted in the cycle after done. There is no queueing.

Optional Feature:
- Macro LEADING_ZERO_BLANK_EN.
- Defined: in LATCH, digits above the most significant nonzero digit are blanked. Digit 0 always shows a numeral, so value 0 displays "0" alone.
- Undefined: all DIGITS digits always show their numerals, including leading zeros. Value 7 displays "007".

Decomposition:
- Package gcd_disp_pkg holds:
  - state enum {IDLE, SHIFT, LATCH};
  - seg7 constant array (10 codes above, plus SEG_BLANK);
  - function for polarity inversion.
- One natural combinational sub-module, seg7_encode: 4-bit BCD plus blank flag in, 7-bit segments out. Instantiate it DIGITS times in a generate loop.
- The double-dabble engine and FSM stay in the top module.

Test Plan (WIDTH=8, active-low, LEADING_ZERO_BLANK_EN defined unless noted):
- Reset then idle -> hex = {7F,7F,7F}, res_ready=1, busy=0, done=0.
- Transfer 255 -> after 9 edges done=1, hex2=24, hex1=12, hex0=12; res_ready=1 one cycle later.
- Transfer 0 -> hex0=40, hex1=7F, hex2=7F. With macro undefined: all three = 40.
- Transfer 100 -> hex2=79, hex1=40, hex0=40. Then transfer 7 right after done -> hex0=78, hex1=hex2=7F.
- Back-pressure: assert res_valid=1 with res_data=42 during a busy conversion -> res_ready=0 and no transfer until IDLE. Then exactly one transfer, and 42 is displayed (hex1=19, hex0=24).
- Reset asserted 4 cycles into the conversion of 123 -> all digits blank, done never pulses, res_ready=1 after the reset edge.

Source files
------------

// File: rtl/gcd_disp_pkg.sv
// Shared types and constants for the GCD result display: FSM states, seven-segment
// code table (bit0=a .. bit6=g, active-high) and helpers for polarity and digit sizing.
package gcd_disp_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StLatch
  } disp_state_e;

  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Index n holds the active-high pattern for decimal digit n.
  localparam logic [9:0][6:0] SEG7 = {
    7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  function automatic logic [6:0] seg_polarity(input logic [6:0] seg, input bit active_low);
    return active_low ? ~seg : seg;
  endfunction

  // Decimal digits needed to show 2^width-1.
  function automatic int unsigned bcd_min_digits(input int unsigned width);
    logic [127:0] v;
    int unsigned  n;
    v = (128'd1 << width) - 128'd1;
    n = 0;
    while (v != 128'd0) begin
      v = v / 128'd10;
      n++;
    end
    return n;
  endfunction

endpackage

// File: rtl/seg7_encode.sv
// Combinational BCD digit to active-high seven-segment pattern; non-decimal codes
// and the blank request both produce an unlit digit.
module seg7_encode
  import gcd_disp_pkg::*;
(
  input  logic [3:0] bcd_i,
  input  logic       blank_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    if (!blank_i && (bcd_i <= 4'd9)) begin
      seg_o = SEG7[bcd_i];
    end
  end

endmodule

// File: rtl/gcd_result_display.sv
// Accepts GCD results over valid/ready, converts them to BCD by double-dabble and
// latches seven-segment digits. Optional macro LEADING_ZERO_BLANK_EN blanks leading zeros.
module gcd_result_display
  import gcd_disp_pkg::*;
#(
  parameter int unsigned WIDTH          = 8,
  parameter int unsigned DIGITS         = 3,
  parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  res_valid,
  input  logic [WIDTH-1:0]      res_data,
  output logic                  res_ready,
  output logic [7*DIGITS-1:0]   hex,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned BcdW = 4 * DIGITS;
  localparam int unsigned CntW = $clog2(WIDTH + 1);
  localparam logic [6:0]  SegOff = seg_polarity(SEG_BLANK, SEG_ACTIVE_LOW);

  if (DIGITS < bcd_min_digits(WIDTH)) begin : g_digits_check
    $error("gcd_result_display: DIGITS too small for WIDTH");
  end

  disp_state_e         state_q, state_d;
  logic [WIDTH-1:0]    bin_q, bin_d;
  logic [BcdW-1:0]     bcd_q, bcd_d, bcd_adj;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                ready_q, ready_d;
  logic                done_q, done_d;
  logic [7*DIGITS-1:0] hex_q, hex_d, hex_enc;
  logic [DIGITS-1:0]   blank;
  logic [DIGITS-1:0][6:0] seg_raw;
  logic                transfer;

  assign transfer = res_valid && ready_q;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (transfer) state_d = StShift;
      StShift: if (cnt_q == CntW'(1)) state_d = StLatch;
      StLatch: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Add 3 to every digit >= 5 ahead of the shift.
  always_comb begin
    bcd_adj = bcd_q;
    for (int d = 0; d < int'(DIGITS); d++) begin
      if (bcd_q[4*d+:4] >= 4'd5) begin
        bcd_adj[4*d+:4] = bcd_q[4*d+:4] + 4'd3;
      end
    end
  end

  // Output / datapath next-state logic
  always_comb begin
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    hex_d   = hex_q;
    done_d  = 1'b0;
    // Ready returns one cycle after the FSM is back in idle.
    ready_d = (state_q == StIdle) && !transfer;
    case (state_q)
      StIdle: begin
        if (transfer) begin
          bin_d = res_data;
          bcd_d = '0;
          cnt_d = CntW'(WIDTH);
        end
      end
      StShift: begin
        {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
        cnt_d          = cnt_q - CntW'(1);
      end
      StLatch: begin
        hex_d  = hex_enc;
        done_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      hex_q   <= {DIGITS{SegOff}};
    end else begin
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      hex_q   <= hex_d;
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  // Blank every digit above the most significant nonzero one; digit 0 always shows.
  always_comb begin
    logic lead;
    lead  = 1'b1;
    blank = '0;
    for (int i = int'(DIGITS) - 1; i > 0; i--) begin
      if (bcd_q[4*i+:4] != 4'd0) lead = 1'b0;
      blank[i] = lead;
    end
  end
`else
  assign blank = '0;
`endif

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    seg7_encode u_seg7_encode (
      .bcd_i   (bcd_q[4*i+:4]),
      .blank_i (blank[i]),
      .seg_o   (seg_raw[i])
    );
    assign hex_enc[7*i+:7] = seg_polarity(seg_raw[i], SEG_ACTIVE_LOW);
  end

  assign res_ready = ready_q;
  assign busy      = (state_q != StIdle);
  assign done      = done_q;
  assign hex       = hex_q;

endmodule
